// File: rtl/cache_mem_arbiter.sv
// Line-memory arbiter between icache and dcache; one whole line transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin instead of dcache priority with a streak cap.
module cache_mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int LINE_WIDTH   = 256,
   parameter int MAX_D_STREAK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] i_dfp_addr,
   input  logic                  i_dfp_read,
   output logic [LINE_WIDTH-1:0] i_dfp_rdata,
   output logic                  i_dfp_resp,
   input  logic [ADDR_WIDTH-1:0] d_dfp_addr,
   input  logic                  d_dfp_read,
   input  logic                  d_dfp_write,
   input  logic [LINE_WIDTH-1:0] d_dfp_wdata,
   output logic [LINE_WIDTH-1:0] d_dfp_rdata,
   output logic                  d_dfp_resp,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp,
   output logic [1:0]            arb_owner
);

   localparam logic [1:0] S_IDLE   = 2'b00;
   localparam logic [1:0] S_BUSY_I = 2'b01;
   localparam logic [1:0] S_BUSY_D = 2'b10;

   logic [1:0] r_state;
   logic       w_i_req;
   logic       w_d_req;
   logic       w_pick_i;
   logic       w_pick_d;
   logic       w_idle;
   logic       w_i_done;
   logic       w_d_done;

   assign w_i_req = i_dfp_read;
   assign w_d_req = d_dfp_read | d_dfp_write;
   assign w_idle  = (r_state == S_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
   logic r_rr_d_first;

   assign w_pick_d = w_d_req & (~w_i_req | r_rr_d_first);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_d_first <= 1'b1;
      end else if (w_idle) begin
         if (w_pick_d)
            r_rr_d_first <= 1'b0;
         else if (w_pick_i)
            r_rr_d_first <= 1'b1;
      end
   end
`else
   localparam logic [3:0] L_MAX = 4'(MAX_D_STREAK);

   logic [3:0] r_streak;

   // dcache wins ties until it has starved a waiting icache L_MAX times
   assign w_pick_d = w_d_req & (~w_i_req | (r_streak != L_MAX));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_streak <= '0;
      end else if (w_idle) begin
         if (w_pick_i)
            r_streak <= '0;
         else if (w_pick_d && w_i_req && r_streak != L_MAX)
            r_streak <= r_streak + 4'd1;
      end
   end
`endif

   assign w_pick_i = w_i_req & ~w_pick_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pick_d) begin
                  r_state   <= S_BUSY_D;
                  mem_addr  <= d_dfp_addr;
                  mem_wdata <= d_dfp_wdata;
                  mem_write <= d_dfp_write;
                  mem_read  <= d_dfp_read & ~d_dfp_write;
               end else if (w_pick_i) begin
                  r_state   <= S_BUSY_I;
                  mem_addr  <= i_dfp_addr;
                  mem_wdata <= '0;
                  mem_write <= 1'b0;
                  mem_read  <= 1'b1;
               end
            end
            S_BUSY_I, S_BUSY_D: begin
               if (mem_resp) begin
                  r_state   <= S_IDLE;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
            end
         endcase
      end
   end

   // state encoding doubles as the owner code
   assign arb_owner = r_state;

   assign w_i_done    = (r_state == S_BUSY_I) & mem_resp;
   assign w_d_done    = (r_state == S_BUSY_D) & mem_resp;
   assign i_dfp_resp  = w_i_done;
   assign d_dfp_resp  = w_d_done;
   assign i_dfp_rdata = w_i_done ? mem_rdata : '0;
   assign d_dfp_rdata = w_d_done ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected grants queued as requests are
// driven, checked by a 3-cycle memory model; follows ARB_ROUND_ROBIN_EN if defined.
module tb_cache_mem_arbiter;

   typedef struct {
      logic [1:0]   own;
      logic [31:0]  addr;
      logic         wr;
      logic [255:0] wdata;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [31:0]  i_dfp_addr;
   logic         i_dfp_read;
   logic [255:0] i_dfp_rdata;
   logic         i_dfp_resp;
   logic [31:0]  d_dfp_addr;
   logic         d_dfp_read;
   logic         d_dfp_write;
   logic [255:0] d_dfp_wdata;
   logic [255:0] d_dfp_rdata;
   logic         d_dfp_resp;
   logic [31:0]  mem_addr;
   logic         mem_read;
   logic         mem_write;
   logic [255:0] mem_wdata;
   logic [255:0] mem_rdata;
   logic         mem_resp;
   logic [1:0]   arb_owner;

   logic m_resp;
   logic spur;
   logic m_busy;
   int   m_cnt;
   exp_t cur;
   exp_t sbq[$];

   int n_cmp;
   int n_err;

   assign mem_resp = m_resp | spur;

   cache_mem_arbiter #(
      .ADDR_WIDTH(32),
      .LINE_WIDTH(256),
      .MAX_D_STREAK(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_dfp_addr(i_dfp_addr),
      .i_dfp_read(i_dfp_read),
      .i_dfp_rdata(i_dfp_rdata),
      .i_dfp_resp(i_dfp_resp),
      .d_dfp_addr(d_dfp_addr),
      .d_dfp_read(d_dfp_read),
      .d_dfp_write(d_dfp_write),
      .d_dfp_wdata(d_dfp_wdata),
      .d_dfp_rdata(d_dfp_rdata),
      .d_dfp_resp(d_dfp_resp),
      .mem_addr(mem_addr),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_resp(mem_resp),
      .arb_owner(arb_owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got,
                      input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] pat(input logic [31:0] a);
      return {8{a ^ 32'h5A5A_0000}};
   endfunction

   function automatic void push(input logic [1:0] own, input logic [31:0] a,
                                input logic wr, input logic [255:0] wd);
      exp_t e;
      e.own = own;
      e.addr = a;
      e.wr = wr;
      e.wdata = wd;
      sbq.push_back(e);
   endfunction

   // memory model: resp 3 cycles after the request rises, random data otherwise
   initial begin
      m_resp = 1'b0;
      m_busy = 1'b0;
      m_cnt = 0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
            mem_rdata = {8{$urandom}};
         end else if (m_resp) begin
            m_resp = 1'b0;
            m_busy = 1'b0;
            mem_rdata = {8{$urandom}};
            chk("idle_owner", {254'd0, arb_owner}, 256'd0);
            chk("idle_req", {254'd0, mem_read, mem_write}, 256'd0);
         end else if (m_busy) begin
            m_cnt++;
            mem_rdata = {8{$urandom}};
            if (m_cnt == 3) begin
               m_resp = 1'b1;
               mem_rdata = pat(cur.addr);
            end
         end else begin
            mem_rdata = {8{$urandom}};
            if (mem_read | mem_write) begin
               m_busy = 1'b1;
               m_cnt = 0;
               if (sbq.size() == 0) begin
                  chk("sb_empty", 256'd1, 256'd0);
               end else begin
                  cur = sbq.pop_front();
                  chk("owner", {254'd0, arb_owner}, {254'd0, cur.own});
                  chk("mem_addr", {224'd0, mem_addr}, {224'd0, cur.addr});
                  chk("mem_read", {255'd0, mem_read}, {255'd0, ~cur.wr});
                  chk("mem_write", {255'd0, mem_write}, {255'd0, cur.wr});
                  if (cur.wr)
                     chk("mem_wdata", mem_wdata, cur.wdata);
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst && m_resp) begin
            chk("i_resp", {255'd0, i_dfp_resp}, {255'd0, cur.own == 2'b01});
            chk("d_resp", {255'd0, d_dfp_resp}, {255'd0, cur.own == 2'b10});
            chk("i_rdata", i_dfp_rdata,
                (cur.own == 2'b01) ? pat(cur.addr) : 256'd0);
            chk("d_rdata", d_dfp_rdata,
                (cur.own == 2'b10) ? pat(cur.addr) : 256'd0);
            chk("mem_addr_hold", {224'd0, mem_addr}, {224'd0, cur.addr});
         end else if (rst && !spur && m_busy) begin
            chk("rdata_gate", i_dfp_rdata | d_dfp_rdata, 256'd0);
         end
      end
   end

   task automatic i_txn(input logic [31:0] a, input bit lat);
      int n;
      i_dfp_addr = a;
      i_dfp_read = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (lat && n == 2)
            chk("i_latency", {255'd0, mem_read && arb_owner == 2'b01}, 256'd1);
      end while (!i_dfp_resp && n < 60);
      if (!i_dfp_resp)
         chk("i_timeout", 256'd0, 256'd1);
      @(posedge clk);
      #1;
      i_dfp_read = 1'b0;
   endtask

   task automatic d_txn(input logic [31:0] a, input logic wr,
                        input logic [255:0] wd, input bit lat);
      int n;
      d_dfp_addr = a;
      d_dfp_wdata = wd;
      d_dfp_write = wr;
      d_dfp_read = ~wr;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (lat && n == 2)
            chk("d_latency", {255'd0, (mem_read | mem_write) && arb_owner == 2'b10},
                256'd1);
      end while (!d_dfp_resp && n < 60);
      if (!d_dfp_resp)
         chk("d_timeout", 256'd0, 256'd1);
      @(posedge clk);
      #1;
      d_dfp_read = 1'b0;
      d_dfp_write = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] pa;
      int n;
      int ni;
      int nd;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0;
      spur = 1'b0;
      i_dfp_addr = '0;
      i_dfp_read = 1'b0;
      d_dfp_addr = '0;
      d_dfp_read = 1'b0;
      d_dfp_write = 1'b0;
      d_dfp_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_req", {254'd0, mem_read, mem_write}, 256'd0);
      chk("rst_owner", {254'd0, arb_owner}, 256'd0);
      chk("rst_addr", {224'd0, mem_addr}, 256'd0);
      chk("rst_wdata", mem_wdata, 256'd0);
      chk("rst_resp", {254'd0, i_dfp_resp, d_dfp_resp}, 256'd0);
      chk("rst_rdata", i_dfp_rdata | d_dfp_rdata, 256'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      push(2'b01, 32'h0000_1240, 1'b0, '0);
      i_txn(32'h0000_1240, 1'b1);

      pa = {8{32'hDEAD_0A0A}};
      push(2'b10, 32'h0000_3A00, 1'b1, pa);
      push(2'b10, 32'h0000_5A00, 1'b0, '0);
      d_txn(32'h0000_3A00, 1'b1, pa, 1'b1);
      d_txn(32'h0000_5A00, 1'b0, '0, 1'b0);

      @(posedge clk);
      #1;
      spur = 1'b1;
      @(negedge clk);
      chk("spur_resp", {254'd0, i_dfp_resp, d_dfp_resp}, 256'd0);
      chk("spur_rdata", i_dfp_rdata | d_dfp_rdata, 256'd0);
      @(posedge clk);
      #1;
      spur = 1'b0;
      @(negedge clk);
      chk("spur_state", {254'd0, arb_owner, mem_read, mem_write}, 256'd0);
      @(posedge clk);
      #1;
      push(2'b01, 32'h0000_2000, 1'b0, '0);
      i_txn(32'h0000_2000, 1'b1);

      push(2'b10, 32'h0000_7000, 1'b0, '0);
      d_dfp_addr = 32'h0000_7000;
      d_dfp_read = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_read && n < 10);
      chk("rst_busy_rise", {255'd0, mem_read}, 256'd1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("async_req", {254'd0, mem_read, mem_write}, 256'd0);
      chk("async_owner", {254'd0, arb_owner}, 256'd0);
      d_dfp_read = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      push(2'b10, 32'h0000_7040, 1'b0, '0);
      d_txn(32'h0000_7040, 1'b0, '0, 1'b1);

      push(2'b01, 32'h0000_2400, 1'b0, '0);
      i_txn(32'h0000_2400, 1'b0);

`ifdef ARB_ROUND_ROBIN_EN
      ni = 3;
      nd = 3;
      push(2'b10, 32'h0000_8000, 1'b0, '0);
      push(2'b01, 32'h0000_1000, 1'b0, '0);
      push(2'b10, 32'h0000_8040, 1'b0, '0);
      push(2'b01, 32'h0000_1040, 1'b0, '0);
      push(2'b10, 32'h0000_8080, 1'b0, '0);
      push(2'b01, 32'h0000_1080, 1'b0, '0);
`else
      ni = 2;
      nd = 4;
      push(2'b10, 32'h0000_8000, 1'b0, '0);
      push(2'b10, 32'h0000_8040, 1'b0, '0);
      push(2'b01, 32'h0000_1000, 1'b0, '0);
      push(2'b10, 32'h0000_8080, 1'b0, '0);
      push(2'b10, 32'h0000_80C0, 1'b0, '0);
      push(2'b01, 32'h0000_1040, 1'b0, '0);
`endif
      fork
         begin
            for (int k = 0; k < ni; k++)
               i_txn(32'h0000_1000 + 32'(k * 64), 1'b0);
         end
         begin
            for (int k = 0; k < nd; k++)
               d_txn(32'h0000_8000 + 32'(k * 64), 1'b0, '0, 1'b0);
         end
      join

      repeat (4) @(negedge clk);
      chk("sb_drained", 256'(sbq.size()), 256'd0);
      chk("end_owner", {254'd0, arb_owner}, 256'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single 256-bit line-memory port between the instruction cache and the data cache.
- Both caches present the same dfp handshake: addr, read, write, rdata, wdata, resp. The request is held until resp.
- Sits between the two cache instances and the burst/memory adapter.
- Grants one whole line transaction at a time, registers the winning request onto the memory side, and routes the response back only to the owner.

Parameters:
ADDR_WIDTH, 32, line address width
LINE_WIDTH, 256, line data width
MAX_D_STREAK, 4, max consecutive dcache grants while icache is waiting (fixed-priority mode only); legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
i_dfp_addr  in  ADDR_WIDTH  icache line address
i_dfp_read  in  1  icache read request
i_dfp_rdata  out  LINE_WIDTH  line data returned to icache
i_dfp_resp  out  1  icache transaction complete
d_dfp_addr  in  ADDR_WIDTH  dcache line address
d_dfp_read  in  1  dcache read request
d_dfp_write  in  1  dcache write-back request
d_dfp_wdata  in  LINE_WIDTH  dcache write-back data
d_dfp_rdata  out  LINE_WIDTH  line data returned to dcache
d_dfp_resp  out  1  dcache transaction complete
mem_addr  out  ADDR_WIDTH  registered line address
mem_read  out  1  memory read
mem_write  out  1  memory write
mem_wdata  out  LINE_WIDTH  registered write data
mem_rdata  in  LINE_WIDTH  memory read data
mem_resp  in  1  memory done
arb_owner  out  2  00 none, 01 icache, 10 dcache

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, all mem_* outputs 0, arb_owner=00, streak counter 0, RR pointer = dcache-first.
  - i/d resp=0 and i/d rdata=0.
- States:
  - IDLE: no transaction outstanding.
  - BUSY_I: icache transaction outstanding.
  - BUSY_D: dcache transaction outstanding.
- Requests: a requester is requesting when read|write is high.
  - If dcache asserts both read and write, it is treated as a write.
- IDLE arbitration, one requester: grant it.
- IDLE arbitration, both requesting (default, fixed priority):
  - Grant dcache unless streak==MAX_D_STREAK; then grant icache.
- Streak counter:
  - Increments on each dcache grant made while icache is requesting, saturating at MAX_D_STREAK.
  - Clears on any icache grant.
  - Holds on a dcache grant made with no icache request.
- On grant:
  - The clock edge moves state to BUSY_x.
  - mem_addr, mem_wdata, mem_read and mem_write load from the winner.
  - Latency: request seen in cycle N, mem_read/mem_write high in cycle N+1.
- BUSY_x:
  - mem_* held stable until mem_resp.
  - In the mem_resp cycle:
    - The owner's resp=1, combinationally.
    - The owner's rdata=mem_rdata, combinationally.
  - Next edge: state=IDLE and mem_read/mem_write=0.
- Owner side channels:
  - The non-owner's resp is always 0.
  - rdata is passed through only in the resp cycle and is 0 otherwise.
- Requester obligations:
  - Hold addr/wdata stable from request until resp.
  - Drop the request in the cycle after resp.
  - A cache can issue a write-back then an allocate back-to-back. The arbiter re-arbitrates between them; no lock is held across the pair.
- Request changes while BUSY: a new request or a changed request from the non-owner is ignored until IDLE. It is not lost, because requesters hold their requests.
- Minimum turnaround: one IDLE cycle between transactions. Back-to-back throughput is one transaction per (memory latency + 2) cycles.
- mem_resp while IDLE is spurious: ignored, no resp generated, no state change.
- Reset asserted mid-transaction: mem_read/mem_write drop immediately, and the transaction is abandoned.
- arb_owner: 01 in BUSY_I, 10 in BUSY_D, 00 in IDLE.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - When both caches request, the arbiter grants the requester not granted most recently. The RR pointer updates on every grant.
  - The streak counter and MAX_D_STREAK are unused, and the counter stays 0.
- Undefined: fixed dcache priority with the MAX_D_STREAK starvation cap, as described in Behaviour.

Test Plan:
1. Icache read only, addr=0x0000_1240, memory responds 3 cycles after mem_read rises.
   -> mem_read=1 and mem_addr=0x0000_1240 one cycle after the request.
   -> i_dfp_resp=1 with i_dfp_rdata=mem_rdata in the mem_resp cycle; d_dfp_resp stays 0.
   -> IDLE on the next cycle.
2. Dcache write-back to 0x0000_3A00 (wdata=pattern A), then dcache read of 0x0000_5A00 immediately after resp.
   -> mem_write with mem_wdata=A first.
   -> One IDLE cycle.
   -> mem_read at 0x0000_5A00.
3. Fixed priority, MAX_D_STREAK=2, both caches requesting continuously (each re-requests after its resp).
   -> Grant order D, D, I, D, D, I.
   -> arb_owner tracks the order.
4. ARB_ROUND_ROBIN_EN defined, both caches requesting continuously.
   -> Grant order D, I, D, I.
5. mem_resp pulsed while IDLE.
   -> No i/d resp, state remains IDLE.
   -> A following icache request completes normally.
6. rst driven low 1 cycle after mem_read rises (during BUSY_D).
   -> mem_read=0 asynchronously, arb_owner=00.
   -> After release, a fresh dcache request is granted in the next cycle.
